i2c_slave_regfile: RTL and testbench

//  I2C target that sits on the SDL/SCL bus downstream of `master`, and completes that master's transfers.

---
 rtl/i2c_slave_regfile_pkg.sv | 21 ++
 rtl/i2c_slave_regfile_if.sv | 14 +
 rtl/i2c_slave_regfile_bus_sync.sv | 46 ++++
 rtl/i2c_slave_regfile.sv | 196 +++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_regfile_pkg.sv
// Shared definitions for the I2C register-file target: FSM states and bus level encodings.
package i2c_slave_regfile_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } state_e;

    localparam logic       SDL_ACK  = 1'b0;   // receiver pulls SDL low to acknowledge
    localparam logic       RW_READ  = 1'b1;   // R/W bit value for a read transfer
    localparam logic [3:0] LAST_BIT = 4'd8;   // bit count once a whole byte has been clocked

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// SCL input plus register-file status outputs of the I2C target, grouped for the top-level port.
interface i2c_slave_regfile_if #(
    parameter int NREG = 4,
    parameter int PW   = $clog2(NREG)
);
    logic                SCL;
    logic [NREG*8-1:0]   regs_q;
    logic                wr_strobe;
    logic [PW-1:0]       wr_ptr;
    logic                busy;

    modport master (output SCL, input regs_q, wr_strobe, wr_ptr, busy);
    modport slave  (input SCL, output regs_q, wr_strobe, wr_ptr, busy);
endinterface

// File: rtl/i2c_slave_regfile_bus_sync.sv
// Synchronizes raw SCL/SDL into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_slave_regfile_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Reset to the idle-bus level so leaving reset never fakes an edge or a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with NREG 8-bit registers behind an auto-incrementing pointer.
// SDL is sampled on synchronized SCL rises and its open-drain drive is updated on SCL falls.
module i2c_slave_regfile
    import i2c_slave_regfile_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h64,
    parameter int         NREG        = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire              SDL,
    i2c_slave_regfile_if.slave bus
);
    localparam int PW = $clog2(NREG);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [6:0]    tx_q, tx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          sdl_low_q, sdl_low_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic          we;
    logic [7:0]    regs_mem_q [NREG];
    logic [7:0]    rd_byte;
    logic [PW-1:0] ptr_next;

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_slave_regfile_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (bus.SCL),
        .sda_i      (SDL),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    assign rd_byte  = regs_mem_q[ptr_q];
    assign ptr_next = (ptr_q == PW'(NREG - 1)) ? '0 : ptr_q + 1'b1;

    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        wr_ptr_d    = wr_ptr_q;
        sdl_low_d   = sdl_low_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        we          = 1'b0;

        if (start_det) begin
            state_d   = ST_ADDR;
            cnt_d     = '0;
            sdl_low_d = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            sdl_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == LAST_BIT) begin
                        cnt_d     = '0;
                        sdl_low_d = 1'b1;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d   = ST_IGNORE;
                                sdl_low_d = 1'b0;
                                busy_d    = 1'b0;
                            end
                        end else if (state_q == ST_PTR) begin
                            state_d = ST_PTR_ACK;
                            ptr_d   = PW'(shift_q % 8'(NREG));
                        end else begin
                            state_d     = ST_WACK;
                            we          = 1'b1;
                            wr_ptr_d    = ptr_q;
                            wr_strobe_d = 1'b1;
                            ptr_d       = ptr_next;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (shift_q[0] == RW_READ) begin
                            state_d   = ST_RDATA;
                            tx_d      = rd_byte[6:0];
                            sdl_low_d = ~rd_byte[7];
                        end else begin
                            state_d   = ST_PTR;
                            sdl_low_d = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WDATA;
                        sdl_low_d = 1'b0;
                    end
                end
                // A zero bit count on a fall means the master just ACKed: load the next byte.
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == '0) begin
                            tx_d      = rd_byte[6:0];
                            sdl_low_d = ~rd_byte[7];
                        end else if (cnt_q == LAST_BIT) begin
                            state_d   = ST_RACK;
                            cnt_d     = '0;
                            sdl_low_d = 1'b0;
                            ptr_d     = ptr_next;
                        end else begin
                            tx_d      = {tx_q[5:0], 1'b0};
                            sdl_low_d = ~tx_q[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda_s == SDL_ACK) begin
                            state_d = ST_RDATA;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            wr_ptr_q    <= '0;
            sdl_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            sdl_low_q   <= sdl_low_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    // NOTE: the register array is reset because its contents are visible on regs_q straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) regs_mem_q[k] <= '0;
        end else if (we) begin
            regs_mem_q[ptr_q] <= shift_q;
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign bus.regs_q[8*k +: 8] = regs_mem_q[k];
    end

    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_ptr    = wr_ptr_q;
    assign bus.busy      = busy_q;
    assign SDL           = sdl_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: a bit-banged I2C master drives the target and checks ACKs, read data and register state.
module tb_i2c_slave_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_low = 1'b0;
    wire  sdl_w;

    i2c_slave_regfile_if #(.NREG(4)) bus_if ();

    pullup pu_sdl (sdl_w);
    assign sdl_w = m_low ? 1'b0 : 1'bz;

    i2c_slave_regfile #(.DEV_ADDR(7'h64), .NREG(4), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .SDL (sdl_w),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int         strobe_cnt = 0;
    logic [1:0] strobe_q [$];
    int         busy_cnt = 0;
    int         viol = 0;
    logic       mon_en = 1'b1;
    logic       p_scl = 1'b1;
    logic       p_sdl = 1'b1;
    logic       p_m   = 1'b0;

    always @(negedge clk) begin
        if (bus_if.wr_strobe === 1'b1) begin
            strobe_cnt++;
            strobe_q.push_back(bus_if.wr_ptr);
        end
        if (bus_if.busy === 1'b1) busy_cnt++;
        if (mon_en && bus_if.SCL && p_scl && (m_low == p_m) && (sdl_w !== p_sdl)) viol++;
        p_scl = bus_if.SCL;
        p_sdl = sdl_w;
        p_m   = m_low;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        tick(10); m_low = 1'b0;
        tick(10); bus_if.SCL = 1'b1;
        tick(10); m_low = 1'b1;
        tick(10); bus_if.SCL = 1'b0;
    endtask

    task automatic bus_stop();
        tick(10); m_low = 1'b1;
        tick(10); bus_if.SCL = 1'b1;
        tick(10); m_low = 1'b0;
        tick(20);
    endtask

    task automatic send_bit(input logic b, output logic s);
        tick(10); m_low = ~b;
        tick(10); bus_if.SCL = 1'b1;
        tick(10); s = sdl_w;
        tick(10); bus_if.SCL = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_lvl, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(ack_lvl, s);
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  ptr;
        logic [7:0]  data;
        logic [2:0]  exp_acks;
        logic [31:0] exp_regs;
        int          exp_strobes;
        logic [1:0]  exp_wr_ptr;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic       a0, a1, a2, a3, a4;
        logic [7:0] rd;
        int         s0, q0, b0;

        vecs[0] = '{7'h64, 8'h01, 8'hDB, 3'b000, 32'h0000_DB00, 1, 2'd1, 1'b1};
        vecs[1] = '{7'h65, 8'h01, 8'h55, 3'b111, 32'h0000_DB00, 0, 2'd0, 1'b0};
        vecs[2] = '{7'h64, 8'h00, 8'hA5, 3'b000, 32'h0000_DBA5, 1, 2'd0, 1'b1};
        vecs[3] = '{7'h64, 8'h06, 8'h3C, 3'b000, 32'h003C_DBA5, 1, 2'd2, 1'b1};
        vecs[4] = '{7'h64, 8'hFF, 8'h7E, 3'b000, 32'h7E3C_DBA5, 1, 2'd3, 1'b1};
        vecs[5] = '{7'h24, 8'h00, 8'h00, 3'b111, 32'h7E3C_DBA5, 0, 2'd0, 1'b0};

        bus_if.SCL = 1'b1;
        rst = 1'b1;
        tick(3);
        check("reset regs", bus_if.regs_q, 32'h0);
        check("reset busy", 32'(bus_if.busy), 32'h0);
        check("reset strobe", 32'(bus_if.wr_strobe), 32'h0);
        check("reset sdl", 32'(sdl_w), 32'h1);
        rst = 1'b0;
        tick(5);

        // Single-byte writes: address match/mismatch, pointer modulo, strobes, busy.
        for (int i = 0; i < 6; i++) begin
            s0 = strobe_cnt;
            b0 = busy_cnt;
            bus_start();
            write_byte({vecs[i].addr, 1'b0}, a0);
            write_byte(vecs[i].ptr, a1);
            write_byte(vecs[i].data, a2);
            bus_stop();
            check($sformatf("v%0d acks", i), 32'({a0, a1, a2}), 32'(vecs[i].exp_acks));
            check($sformatf("v%0d regs", i), bus_if.regs_q, vecs[i].exp_regs);
            check($sformatf("v%0d strobes", i), 32'(strobe_cnt - s0), 32'(vecs[i].exp_strobes));
            if (vecs[i].exp_strobes > 0)
                check($sformatf("v%0d wr_ptr", i), 32'(strobe_q[strobe_q.size()-1]), 32'(vecs[i].exp_wr_ptr));
            check($sformatf("v%0d busy seen", i), 32'(busy_cnt > b0), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d busy after stop", i), 32'(bus_if.busy), 32'h0);
        end

        // Pointer write, repeated START, read with NACK.
        bus_start();
        write_byte(8'hC8, a0);
        write_byte(8'h01, a1);
        bus_start();
        write_byte(8'hC9, a2);
        read_byte(1'b1, rd);
        check("rs acks", 32'({a0, a1, a2}), 32'h0);
        check("rs data", 32'(rd), 32'hDB);
        tick(5);
        check("rs busy after nack", 32'(bus_if.busy), 32'h0);
        check("rs sdl released", 32'(sdl_w), 32'h1);
        bus_stop();

        // Multi-byte write wrapping past the last register.
        s0 = strobe_cnt;
        q0 = strobe_q.size();
        bus_start();
        write_byte(8'hC8, a0);
        write_byte(8'h03, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        write_byte(8'h33, a4);
        bus_stop();
        check("mw acks", 32'({a0, a1, a2, a3, a4}), 32'h0);
        check("mw regs", bus_if.regs_q, 32'h113C_3322);
        check("mw strobes", 32'(strobe_cnt - s0), 32'd3);
        check("mw wr_ptr0", 32'(strobe_q[q0]), 32'd3);
        check("mw wr_ptr1", 32'(strobe_q[q0+1]), 32'd0);
        check("mw wr_ptr2", 32'(strobe_q[q0+2]), 32'd1);

        // Pointer-only write then STOP, followed by a 4-byte wrapping read.
        bus_start();
        write_byte(8'hC8, a0);
        write_byte(8'h02, a1);
        bus_stop();
        bus_start();
        write_byte(8'hC9, a2);
        check("mr acks", 32'({a0, a1, a2}), 32'h0);
        read_byte(1'b0, rd); check("mr byte0", 32'(rd), 32'h3C);
        read_byte(1'b0, rd); check("mr byte1", 32'(rd), 32'h11);
        read_byte(1'b0, rd); check("mr byte2", 32'(rd), 32'h22);
        read_byte(1'b1, rd); check("mr byte3", 32'(rd), 32'h33);
        bus_stop();

        // Data byte cut short by STOP is discarded.
        s0 = strobe_cnt;
        bus_start();
        write_byte(8'hC8, a0);
        write_byte(8'h00, a1);
        send_bit(1'b1, a2);
        send_bit(1'b0, a2);
        send_bit(1'b1, a2);
        send_bit(1'b0, a2);
        bus_stop();
        check("cut strobes", 32'(strobe_cnt - s0), 32'd0);
        check("cut regs", bus_if.regs_q, 32'h113C_3322);
        bus_start();
        write_byte(8'hC9, a2);
        read_byte(1'b1, rd);
        bus_stop();
        check("cut acks", 32'({a0, a1, a2}), 32'h0);
        check("cut readback", 32'(rd), 32'h22);
        check("no sdl drive during scl high", 32'(viol), 32'd0);

        // Reset in the middle of a read data bit.
        bus_start();
        write_byte(8'hC8, a0);
        write_byte(8'h00, a1);
        bus_stop();
        bus_start();
        write_byte(8'hC9, a2);
        check("rst acks", 32'({a0, a1, a2}), 32'h0);
        mon_en = 1'b0;
        tick(20);
        bus_if.SCL = 1'b1;
        tick(5);
        check("rst pre drive", 32'(sdl_w), 32'h0);
        rst = 1'b1;
        #1;
        check("rst sdl released", 32'(sdl_w), 32'h1);
        check("rst regs", bus_if.regs_q, 32'h0);
        check("rst busy", 32'(bus_if.busy), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(3);
        bus_if.SCL = 1'b0;
        tick(20);
        mon_en = 1'b1;
        s0 = strobe_cnt;
        q0 = strobe_q.size();
        bus_start();
        write_byte(8'hC8, a0);
        write_byte(8'h02, a1);
        write_byte(8'h5A, a2);
        bus_stop();
        check("post rst acks", 32'({a0, a1, a2}), 32'h0);
        check("post rst regs", bus_if.regs_q, 32'h005A_0000);
        check("post rst strobes", 32'(strobe_cnt - s0), 32'd1);
        check("post rst wr_ptr", 32'(strobe_q[q0]), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
